uart_rx_even_parity: RTL and testbench
======================================

# uart_rx_even_parity

Standalone UART receiver for the 8-data-bit, even-parity, 1-stop-bit serial frame produced by the team's UART transmitter: start bit (0), 8 data bits LSB first, even parity bit, stop bit (1). It oversamples the incoming line, samples each bit at mid-bit, checks parity and framing, and delivers each byte through a valid/ready holding register. The block sits between the serial pin and the APB register interface.

## Interface
- OVERSAMPLE, 16: oversample ticks per bit period; must be even and ≥4.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_select  input  32  clk cycles per oversample tick; a value of 0 is treated as 1.
- rx_enable  input  1  when high, a new frame may start; sampled only in IDLE.
- ser_in  input  1  asynchronous serial line; idle level is high.
- rx_ready  input  1  consumer accepts rx_data in any cycle where rx_valid=1 and rx_ready=1.
- clr_overrun  input  1  clears the overrun flag.
- rx_data  output  8  received byte.
- rx_valid  output  1  holding register is full.
- parity_err  output  1  parity mismatch for the byte in rx_data.
- frame_err  output  1  stop bit sampled as 0 for the byte in rx_data.
- overrun  output  1  sticky flag: a completed frame was dropped because the holding register was full.
- busy  output  1  high in every state except IDLE.

## Operation
- ser_in passes through a 2-flop synchronizer (s_in). Edge detection uses a third flop holding the previous s_in.
- Tick generator: the counter is held at 0 in IDLE. In other states it counts 0..div-1, where div = max(baud_select,1). tick=1 in the cycle when count == div-1, then the counter wraps to 0.
- Oversample counter os_cnt:
  - cleared when a frame starts;
  - increments on each tick;
  - each sample point below is the tick on which os_cnt reaches the stated value, after which os_cnt clears.
- State machine:
  - IDLE → START when rx_enable=1 and s_in falls (prev=1, s_in=0).
  - START: at OVERSAMPLE/2 ticks, sample s_in. If s_in=1, the start was false: return to IDLE and report nothing. Otherwise go to DATA with bit index 0.
  - DATA: every OVERSAMPLE ticks, shift s_in into shift[idx] (LSB first) and fold it into the running XOR. After idx=7 is sampled, go to PARITY.
  - PARITY: at OVERSAMPLE ticks, sample the parity bit. p_err = sampled bit XOR XOR(shift). A correct even-parity bit makes p_err=0.
  - STOP: at OVERSAMPLE ticks, sample the stop bit. f_err = ~s_in. Complete the frame and go to IDLE.
- Frame completion (the cycle after the stop sample):
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in that cycle: load rx_data=shift, parity_err=p_err, frame_err=f_err, rx_valid=1.
  - Otherwise: drop the frame, set overrun=1, and leave the holding register unchanged.
- Consumer handshake: rx_valid clears in the cycle after rx_valid & rx_ready, unless a load occurs in that same cycle (then rx_valid stays 1 with the new data).
- overrun:
  - clears on clr_overrun=1;
  - a set and a clr_overrun in the same cycle leave overrun=1.
- rx_enable falling mid-frame does not abort the frame; it only blocks the next start.
- A stop bit sampled as 0 (break): the machine returns to IDLE. No new start occurs until s_in has returned high and falls again.
- A frame is never restarted while busy=1. Edges on ser_in outside IDLE are ignored.

## Timing
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Internally: state IDLE, all counters 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame immediately. The next cycle after reset release is in IDLE.
- Synchronizer latency is 2 clk. busy rises 1 clk after the falling edge is seen on s_in.
- Sample points are measured in ticks from the start: OVERSAMPLE/2 (start bit), +OVERSAMPLE for each of the 8 data bits, then parity, then stop.
  - With OVERSAMPLE=16, the stop bit is sampled at tick 168.
  - rx_valid rises 1 clk after the stop sample.
- busy falls in the same cycle rx_valid rises (or overrun sets).
- With OVERSAMPLE=16 and baud_select=4, one bit period is 64 clk.

## Test plan
All scenarios use OVERSAMPLE=16 and baud_select=4 (64 clk per bit).
- Frame 0xA5 with parity 0 and stop 1 → rx_data=0xA5, rx_valid=1, parity_err=0, frame_err=0. rx_ready pulse → rx_valid=0 on the next clk.
- Frame 0x01 with parity bit 0 (wrong) → rx_data=0x01, parity_err=1, frame_err=0.
- 20-clk low glitch on an idle line → rx_valid stays 0, busy returns to 0 within 40 clk, and a following frame 0x5A is received cleanly.
- Frame 0xFF with stop bit 0 → rx_data=0xFF, frame_err=1, parity_err=0. No new frame starts until the line goes high and falls again.
- Frames 0x11 then 0x22 with rx_ready=0 → rx_data stays 0x11 and overrun=1. clr_overrun → overrun=0. rx_ready asserted in the exact completion cycle of 0x22 → rx_data=0x22, rx_valid=1, overrun stays 0.
- rst pulsed during data bit 3 → all outputs at reset values. A subsequent frame 0x3C gives rx_data=0x3C with no errors.

Source files
------------

// File: rtl/uart_rx_even_parity.sv
// UART receiver for 8-bit, even-parity, 1-stop-bit frames.
// The line is oversampled, each bit is taken at mid-bit, and the received
// byte is delivered through a valid/ready holding register with parity,
// framing and overrun status.
module uart_rx_even_parity #(
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] baud_select,
    input  logic        rx_enable,
    input  logic        ser_in,
    input  logic        rx_ready,
    input  logic        clr_overrun,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] FULL_M1 = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [31:0]      tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             xor_q, xor_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             s_in;
    logic [31:0]      div;
    logic             tick;
    logic             sample;
    logic             load;
    logic             drop;

    assign s_in = sync2_q;
    assign div  = (baud_select == 32'd0) ? 32'd1 : baud_select;
    assign tick = (state_q != S_IDLE) && (tick_cnt_q == div - 32'd1);

    // Tick divider and oversample counter; sample marks a mid-bit sample point.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        os_cnt_d   = os_cnt_q;
        sample     = 1'b0;
        if (state_q == S_IDLE) begin
            tick_cnt_d = 32'd0;
        end else if (tick) begin
            tick_cnt_d = 32'd0;
        end else begin
            tick_cnt_d = tick_cnt_q + 32'd1;
        end
        case (state_q)
            S_START:                   sample = tick && (os_cnt_q == HALF_M1);
            S_DATA, S_PARITY, S_STOP:  sample = tick && (os_cnt_q == FULL_M1);
            default:                   sample = 1'b0;
        endcase
        if (state_q == S_IDLE || state_q == S_DONE || sample) begin
            os_cnt_d = '0;
        end else if (tick) begin
            os_cnt_d = os_cnt_q + OS_W'(1);
        end
    end

    // Frame state machine: next state and per-bit datapath updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        xor_d   = xor_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE: begin
                if (rx_enable && prev_q && !s_in) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    if (s_in) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                        xor_d   = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d[idx_q] = s_in;
                    xor_d          = xor_q ^ s_in;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_d  = s_in ^ xor_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    ferr_d  = ~s_in;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign load = (state_q == S_DONE) && (!rx_valid_q || rx_ready);
    assign drop = (state_q == S_DONE) && rx_valid_q && !rx_ready;

    // Holding register, consumer handshake and sticky overrun flag.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        if (load) begin
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_q;
            rx_valid_d   = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d   = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // State, counters, synchronizer and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            tick_cnt_q   <= 32'd0;
            os_cnt_q     <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'd0;
            xor_q        <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= ser_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            tick_cnt_q   <= tick_cnt_d;
            os_cnt_q     <= os_cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            xor_q        <= xor_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_even_parity.sv
// Testbench for uart_rx_even_parity: directed frame table, hand-written
// corner-case sequences and randomized frames checked against a frame-level model.
module tb_uart_rx_even_parity;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] baud_select;
    logic        rx_enable;
    logic        ser_in;
    logic        rx_ready;
    logic        clr_overrun;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int total = 0;
    int bad   = 0;

    uart_rx_even_parity #(.OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_select (baud_select),
        .rx_enable   (rx_enable),
        .ser_in      (ser_in),
        .rx_ready    (rx_ready),
        .clr_overrun (clr_overrun),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one full frame; optional one-cycle rx_ready pulse and rx_enable drop.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int bitclk, input int ready_cyc, input int en_off_cyc);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int n = 0; n < 11 * bitclk; n++) begin
            ser_in   = bits[n / bitclk];
            rx_ready = (n == ready_cyc);
            if (n == en_off_cyc) rx_enable = 1'b0;
            cyc(1);
        end
        ser_in   = 1'b1;
        rx_ready = 1'b0;
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [6];
        logic [10:0] bits;
        logic        m_valid, m_pe, m_fe, m_ovr;
        logic [7:0]  m_data;
        logic [7:0]  d;
        logic        p, s;
        int          sel, div;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        tbl[4] = '{8'h7F, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

        rst = 1'b1; baud_select = 32'd4; rx_enable = 1'b1; ser_in = 1'b1;
        rx_ready = 1'b0; clr_overrun = 1'b0;
        cyc(4);
        chk8("reset_data", rx_data, 8'h00);
        chk1("reset_valid", rx_valid, 1'b0);
        chk1("reset_perr", parity_err, 1'b0);
        chk1("reset_ferr", frame_err, 1'b0);
        chk1("reset_ovr", overrun, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        rst = 1'b0;
        cyc(10);

        // Glitch shorter than half a bit: false start.
        ser_in = 1'b0;
        cyc(10);
        chk1("glitch_busy_hi", busy, 1'b1);
        cyc(10);
        ser_in = 1'b1;
        cyc(20);
        chk1("glitch_busy_lo", busy, 1'b0);
        chk1("glitch_valid", rx_valid, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 64, -1, -1);
        chk8("after_glitch_data", rx_data, 8'h5A);
        chk1("after_glitch_valid", rx_valid, 1'b1);
        chk1("after_glitch_perr", parity_err, 1'b0);
        pulse_ready();
        chk1("after_glitch_consume", rx_valid, 1'b0);

        // Directed frame table.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].p, tbl[i].s, 64, -1, -1);
            chk1("tbl_valid", rx_valid, 1'b1);
            chk8("tbl_data", rx_data, tbl[i].exp_d);
            chk1("tbl_perr", parity_err, tbl[i].exp_pe);
            chk1("tbl_ferr", frame_err, tbl[i].exp_fe);
            chk1("tbl_busy", busy, 1'b0);
            if (!tbl[i].s) begin
                ser_in = 1'b0;
                cyc(200);
                chk1("break_no_restart", busy, 1'b0);
                ser_in = 1'b1;
                cyc(20);
            end
            pulse_ready();
            chk1("tbl_consume", rx_valid, 1'b0);
        end

        // rx_enable dropped mid-frame: frame completes, next frame blocked.
        send_frame(8'h96, 1'b0, 1'b1, 64, -1, 300);
        chk8("en_drop_data", rx_data, 8'h96);
        chk1("en_drop_valid", rx_valid, 1'b1);
        pulse_ready();
        send_frame(8'h55, 1'b0, 1'b1, 64, -1, -1);
        chk1("disabled_valid", rx_valid, 1'b0);
        chk1("disabled_busy", busy, 1'b0);
        rx_enable = 1'b1;
        cyc(10);

        // Overrun and same-cycle accept on completion.
        send_frame(8'h11, 1'b0, 1'b1, 64, -1, -1);
        chk8("ovr_first_data", rx_data, 8'h11);
        send_frame(8'h22, 1'b0, 1'b1, 64, -1, -1);
        chk8("ovr_keep_data", rx_data, 8'h11);
        chk1("ovr_set", overrun, 1'b1);
        chk1("ovr_valid", rx_valid, 1'b1);
        chk1("ovr_busy", busy, 1'b0);
        pulse_clr();
        chk1("ovr_clr", overrun, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 64, 675, -1);
        chk8("accept_same_cycle_data", rx_data, 8'h22);
        chk1("accept_same_cycle_valid", rx_valid, 1'b1);
        chk1("accept_same_cycle_ovr", overrun, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, 64, -1, -1);
        chk1("ovr_again", overrun, 1'b1);
        chk8("ovr_again_data", rx_data, 8'h22);

        // Reset during data bit 3.
        bits = {1'b1, 1'b0, 8'h3C, 1'b0};
        for (int n = 0; n < 280; n++) begin
            ser_in = bits[n / 64];
            cyc(1);
        end
        chk1("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        ser_in = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk8("midrst_data", rx_data, 8'h00);
        chk1("midrst_valid", rx_valid, 1'b0);
        chk1("midrst_perr", parity_err, 1'b0);
        chk1("midrst_ferr", frame_err, 1'b0);
        chk1("midrst_ovr", overrun, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        cyc(1);
        chk1("postrst_idle", busy, 1'b0);
        cyc(20);
        send_frame(8'h3C, 1'b0, 1'b1, 64, -1, -1);
        chk8("postrst_data", rx_data, 8'h3C);
        chk1("postrst_valid", rx_valid, 1'b1);
        chk1("postrst_perr", parity_err, 1'b0);
        chk1("postrst_ferr", frame_err, 1'b0);
        pulse_ready();

        // Randomized frames against a frame-level model.
        m_valid = 1'b0; m_data = 8'h3C; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 3) sel = 4;
            baud_select = 32'(sel);
            div = (sel == 0) ? 1 : sel;
            d = 8'($urandom);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s, 16 * div, -1, -1);
            cyc($urandom_range(5, 40));
            if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = d;
                m_pe    = p ^ (^d);
                m_fe    = !s;
            end else begin
                m_ovr = 1'b1;
            end
            chk1("rnd_valid", rx_valid, m_valid);
            chk8("rnd_data", rx_data, m_data);
            chk1("rnd_perr", parity_err, m_pe);
            chk1("rnd_ferr", frame_err, m_fe);
            chk1("rnd_ovr", overrun, m_ovr);
            chk1("rnd_busy", busy, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                pulse_ready();
                m_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                m_ovr = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
